// File: rtl/pulse_sound_channel.sv
// Single-voice pulse tone generator: 8-step waveform, width+1 high steps,
// amplitude volume << AMP_SHIFT, registered signed sample.
module pulse_sound_channel #(
  parameter int AMP_SHIFT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] period,
  input  logic [4:0]  volume,
  input  logic [2:0]  width,
  output logic [23:0] sample
);

  logic [15:0] cnt_q,    cnt_d;
  logic [2:0]  step_q,   step_d;
  logic [23:0] sample_q, sample_d;
  logic [23:0] amp;
  logic        high;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      step_q   <= '0;
      sample_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      sample_q <= sample_d;
    end
  end

  // >= rather than == so lowering period below the running count wraps at once
  always_comb begin
    cnt_d  = cnt_q;
    step_d = step_q;
    if (period != 16'd0) begin
      if (cnt_q >= period - 16'd1) begin
        cnt_d  = '0;
        step_d = step_q + 3'd1;
      end else begin
        cnt_d  = cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    amp      = {19'd0, volume} << AMP_SHIFT;
    high     = (step_q <= width);
    sample_d = high ? amp : (24'd0 - amp);
  end

  assign sample = sample_q;

endmodule

// File: tb/tb_pulse_sound_channel.sv
// Self-checking bench for pulse_sound_channel: directed scenarios plus a
// randomized run against a step/dwell reference model.
module tb_pulse_sound_channel;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] period;
  logic [4:0]  volume;
  logic [2:0]  width;
  logic [23:0] sample;

  int checks   = 0;
  int failures = 0;

  // reference model: step index and clocks already spent in it
  int m_step  = 0;
  int m_dwell = 0;
  int exp_val = 0;

  pulse_sound_channel #(.AMP_SHIFT(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .period (period),
    .volume (volume),
    .width  (width),
    .sample (sample)
  );

  always #5 clk = ~clk;

  // One rising edge; the model consumes the inputs present before the edge.
  task automatic tick();
    int amp;
    @(posedge clk);
    if (reset) begin
      m_step  = 0;
      m_dwell = 0;
      exp_val = 0;
    end else begin
      amp     = int'(volume) * 65536;
      exp_val = (m_step <= int'(width)) ? amp : -amp;
      if (period != 0) begin
        m_dwell = m_dwell + 1;
        if (m_dwell >= int'(period)) begin
          m_dwell = 0;
          m_step  = (m_step + 1) % 8;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    period = 16'd2; volume = 5'd4; width = 3'd3;
    do_reset(2);
    checks++;
    if (sample !== 24'h000000) begin
      failures++;
      $display("FAIL reset_value: got %h expected 000000", sample);
    end
  endtask

  task automatic test_basic();
    logic [23:0] want;
    period = 16'd2; volume = 5'd4; width = 3'd3;
    do_reset(1);
    for (int k = 0; k < 32; k++) begin
      tick();
      want = ((k % 16) < 8) ? 24'h040000 : 24'hFC0000;
      checks++;
      if (sample !== want) begin
        failures++;
        $display("FAIL basic_wave edge %0d: got %h expected %h", k, sample, want);
      end
    end
  endtask

  task automatic test_widths();
    logic [23:0] want;
    period = 16'd2; volume = 5'd4; width = 3'd0;
    do_reset(1);
    for (int k = 0; k < 32; k++) begin
      tick();
      want = ((k % 16) < 2) ? 24'h040000 : 24'hFC0000;
      checks++;
      if (sample !== want) begin
        failures++;
        $display("FAIL width0 edge %0d: got %h expected %h", k, sample, want);
      end
    end
    width = 3'd7;
    do_reset(1);
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if (sample !== 24'h040000) begin
        failures++;
        $display("FAIL width7 edge %0d: got %h expected 040000", k, sample);
      end
    end
  endtask

  task automatic test_fast_period1();
    logic [23:0] want;
    period = 16'd1; volume = 5'd31; width = 3'd3;
    do_reset(1);
    for (int k = 0; k < 24; k++) begin
      tick();
      want = ((k % 8) < 4) ? 24'h1F0000 : 24'hE10000;
      checks++;
      if (sample !== want) begin
        failures++;
        $display("FAIL period1_vol31 edge %0d: got %h expected %h", k, sample, want);
      end
    end
    volume = 5'd0;
    tick();
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (sample !== 24'h000000) begin
        failures++;
        $display("FAIL volume0 edge %0d: got %h expected 000000", k, sample);
      end
    end
  endtask

  task automatic test_period_change();
    period = 16'd10; volume = 5'd4; width = 3'd0;
    do_reset(1);
    repeat (7) tick();
    period = 16'd3;
    tick();
    checks++;
    if (sample !== 24'h040000) begin
      failures++;
      $display("FAIL pchg_last_step0: got %h expected 040000", sample);
    end
    tick();
    checks++;
    if (sample !== 24'hFC0000) begin
      failures++;
      $display("FAIL pchg_wrap: got %h expected FC0000", sample);
    end
    for (int k = 0; k < 30; k++) begin
      tick();
      checks++;
      if (int'($signed(sample)) != exp_val) begin
        failures++;
        $display("FAIL pchg_model edge %0d: got %h expected %0d", k, sample, exp_val);
      end
    end
  endtask

  task automatic test_period_zero();
    period = 16'd0; volume = 5'd1; width = 3'd3;
    do_reset(1);
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if (sample !== 24'h010000) begin
        failures++;
        $display("FAIL period0_hold edge %0d: got %h expected 010000", k, sample);
      end
    end
    width  = 3'd6;
    volume = 5'd5;
    tick();
    checks++;
    if (sample !== 24'h050000) begin
      failures++;
      $display("FAIL period0_volume: got %h expected 050000", sample);
    end
  endtask

  task automatic test_mid_reset();
    period = 16'd2; volume = 5'd4; width = 3'd3;
    do_reset(1);
    repeat (10) tick();
    checks++;
    if (sample !== 24'hFC0000) begin
      failures++;
      $display("FAIL midrst_low_phase: got %h expected FC0000", sample);
    end
    do_reset(1);
    checks++;
    if (sample !== 24'h000000) begin
      failures++;
      $display("FAIL midrst_zero: got %h expected 000000", sample);
    end
    tick();
    checks++;
    if (sample !== 24'h040000) begin
      failures++;
      $display("FAIL midrst_restart: got %h expected 040000", sample);
    end
  endtask

  task automatic test_random();
    period = 16'd3; volume = 5'd7; width = 3'd2;
    do_reset(1);
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 15) == 0) period = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 9) == 0)  volume = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0)  width = 3'($urandom_range(0, 7));
      reset = ($urandom_range(0, 63) == 0);
      tick();
      checks++;
      if (int'($signed(sample)) != exp_val) begin
        failures++;
        $display("FAIL random edge %0d: got %h expected %0d", k, sample, exp_val);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    period = '0;
    volume = '0;
    width  = '0;
    test_reset();
    test_basic();
    test_widths();
    test_fast_period1();
    test_period_change();
    test_period_zero();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
